// File: rtl/affinex_pkg.sv
// Shared types and constants for the affine-transform peripheral.
// Used by the batch sequencer and the MMIO register file.
package affinex_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned CntWDefault  = 8;

  // MMIO byte offsets of the batch registers, decoded by the register file
  localparam logic [7:0] BatchCtrlOffset  = 8'h40;
  localparam logic [7:0] BatchLenOffset   = 8'h44;
  localparam logic [7:0] BatchCountOffset = 8'h48;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFetch    = 3'd1,
    StLaunch   = 3'd2,
    StWaitCore = 3'd3,
    StStore    = 3'd4,
    StDrain    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/affinex_batch_seq_if.sv
// Datapath bundle between the batch sequencer, the input/output FIFOs and the affine core.
// master = sequencer side, slave = FIFOs + core side.
interface affinex_batch_seq_if
  import affinex_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic              in_empty;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic              in_pop;

  logic              core_start;
  logic [DATA_W-1:0] core_x;
  logic [DATA_W-1:0] core_y;
  logic              core_done;
  logic [DATA_W-1:0] core_out_x;
  logic [DATA_W-1:0] core_out_y;

  logic              out_full;
  logic              out_push;
  logic [DATA_W-1:0] out_x;
  logic [DATA_W-1:0] out_y;

  modport master (
    input  in_empty, in_x, in_y, core_done, core_out_x, core_out_y, out_full,
    output in_pop, core_start, core_x, core_y, out_push, out_x, out_y
  );

  modport slave (
    output in_empty, in_x, in_y, core_done, core_out_x, core_out_y, out_full,
    input  in_pop, core_start, core_x, core_y, out_push, out_x, out_y
  );

endinterface

// File: rtl/affinex_batch_seq.sv
// Batch sequencer: fetches points from the input FIFO, runs each through the affine core,
// stores results to the output FIFO and raises a sticky irq when the programmed batch completes.
module affinex_batch_seq
  import affinex_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cfg_start,
  input  logic [CNT_W-1:0]     i_cfg_len,
  input  logic                 i_cfg_abort,
  input  logic                 i_irq_clear,
  affinex_batch_seq_if.master  io_bus,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_done_count,
  output logic                 o_aborted,
  output logic                 o_irq
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  w_len_nxt;
  logic [CNT_W-1:0]  r_done_count;
  logic [CNT_W-1:0]  w_done_count_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_aborted;
  logic              w_aborted_nxt;
  logic              r_irq;
  logic              w_irq_nxt;
  logic              w_irq_set;
  logic [DATA_W-1:0] r_core_x;
  logic [DATA_W-1:0] r_core_y;
  logic [DATA_W-1:0] w_core_x_nxt;
  logic [DATA_W-1:0] w_core_y_nxt;
  logic [DATA_W-1:0] r_out_x;
  logic [DATA_W-1:0] r_out_y;
  logic [DATA_W-1:0] w_out_x_nxt;
  logic [DATA_W-1:0] w_out_y_nxt;
  logic              w_in_pop;
  logic              w_core_start;
  logic              w_out_push;

  assign w_cnt_inc = r_done_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_len        <= '0;
      r_done_count <= '0;
      r_aborted    <= 1'b0;
      r_irq        <= 1'b0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_done_count <= w_done_count_nxt;
      r_aborted    <= w_aborted_nxt;
      r_irq        <= w_irq_nxt;
      r_core_x     <= w_core_x_nxt;
      r_core_y     <= w_core_y_nxt;
      r_out_x      <= w_out_x_nxt;
      r_out_y      <= w_out_y_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_len_nxt        = r_len;
    w_done_count_nxt = r_done_count;
    w_aborted_nxt    = r_aborted;
    w_irq_set        = 1'b0;
    w_core_x_nxt     = r_core_x;
    w_core_y_nxt     = r_core_y;
    w_out_x_nxt      = r_out_x;
    w_out_y_nxt      = r_out_y;
    w_in_pop         = 1'b0;
    w_core_start     = 1'b0;
    w_out_push       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_cfg_start) begin
          if (i_cfg_len != '0) begin
            w_len_nxt        = i_cfg_len;
            w_done_count_nxt = '0;
            w_aborted_nxt    = 1'b0;
            w_state_nxt      = StFetch;
          end else begin
            w_irq_set = 1'b1;
          end
        end
      end
      StFetch: begin
        // Abort outranks the pop so the FIFO head is left untouched
        if (i_cfg_abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end else if (!io_bus.in_empty) begin
          w_in_pop     = 1'b1;
          w_core_x_nxt = io_bus.in_x;
          w_core_y_nxt = io_bus.in_y;
          w_state_nxt  = StLaunch;
        end
      end
      StLaunch: begin
        if (i_cfg_abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end else begin
          w_core_start = 1'b1;
          w_state_nxt  = StWaitCore;
        end
      end
      StWaitCore: begin
        // Core is already running: an abort must still absorb its done pulse
        if (i_cfg_abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = io_bus.core_done ? StIdle : StDrain;
        end else if (io_bus.core_done) begin
          w_out_x_nxt = io_bus.core_out_x;
          w_out_y_nxt = io_bus.core_out_y;
          w_state_nxt = StStore;
        end
      end
      StStore: begin
        if (i_cfg_abort) begin
          w_aborted_nxt = 1'b1;
          w_state_nxt   = StIdle;
        end else if (!io_bus.out_full) begin
          w_out_push       = 1'b1;
          w_done_count_nxt = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_irq_set   = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_state_nxt = StFetch;
          end
        end
      end
      StDrain: begin
        if (io_bus.core_done) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    w_irq_nxt = w_irq_set | (r_irq & ~i_irq_clear);
  end

  assign io_bus.in_pop     = w_in_pop;
  assign io_bus.core_start = w_core_start;
  assign io_bus.core_x     = r_core_x;
  assign io_bus.core_y     = r_core_y;
  assign io_bus.out_push   = w_out_push;
  assign io_bus.out_x      = r_out_x;
  assign io_bus.out_y      = r_out_y;

  assign o_busy       = (r_state != StIdle);
  assign o_done_count = r_done_count;
  assign o_aborted    = r_aborted;
  assign o_irq        = r_irq;

endmodule

// File: tb/tb_affinex_batch_seq.sv
// Scoreboard bench for affinex_batch_seq: FIFO and core models drive the bus, expected results
// are queued when points are loaded and a monitor checks every output push.
module tb_affinex_batch_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start;
  logic [7:0] cfg_len;
  logic       cfg_abort;
  logic       irq_clear;
  logic       busy;
  logic [7:0] done_count;
  logic       aborted;
  logic       irq;

  affinex_batch_seq_if #(.DATA_W(16)) bus ();

  affinex_batch_seq #(
    .DATA_W(16),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_start (cfg_start),
    .i_cfg_len   (cfg_len),
    .i_cfg_abort (cfg_abort),
    .i_irq_clear (irq_clear),
    .io_bus      (bus),
    .o_busy      (busy),
    .o_done_count(done_count),
    .o_aborted   (aborted),
    .o_irq       (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] in_q[$];
  logic [31:0] sb_q[$];
  longint      push_cyc[$];
  longint      cyc = 0;
  int          k_lat = 4;
  bit          starve, force_full, rand_full, rand_starve;
  int          n_tests = 0, n_fail = 0;
  int          n_pop = 0, n_start = 0, n_push = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Input FIFO, affine core (x+1, y+1 after k_lat cycles) and output FIFO models
  initial begin : env
    logic        s_pop, s_start;
    logic [15:0] s_cx, s_cy, r_x, r_y;
    int          cd;
    cd = 0; r_x = '0; r_y = '0;
    bus.in_empty = 1'b1; bus.in_x = '0; bus.in_y = '0;
    bus.core_done = 1'b0; bus.core_out_x = '0; bus.core_out_y = '0;
    bus.out_full = 1'b0;
    forever begin
      @(negedge clk);
      s_pop = bus.in_pop; s_start = bus.core_start; s_cx = bus.core_x; s_cy = bus.core_y;
      @(posedge clk); #1;
      if (!rst_n) begin cd = 0; s_pop = 1'b0; s_start = 1'b0; end
      if (s_pop) begin
        n_pop++;
        if (in_q.size() > 0) void'(in_q.pop_front());
      end
      if (s_start) begin
        n_start++; cd = k_lat; r_x = s_cx + 16'd1; r_y = s_cy + 16'd1;
      end
      bus.core_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin bus.core_done = 1'b1; bus.core_out_x = r_x; bus.core_out_y = r_y; end
      end
      bus.in_empty = (in_q.size() == 0) || starve || (rand_starve && $urandom_range(0, 3) == 0);
      if (in_q.size() > 0) {bus.in_x, bus.in_y} = in_q[0];
      bus.out_full = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
    end
  end

  initial begin : monitor
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.in_pop || bus.core_start || bus.out_push)
          chk("pulse_exclusive", int'(bus.in_pop) + int'(bus.core_start) + int'(bus.out_push), 1);
        if (bus.out_push) begin
          n_push++;
          if (sb_q.size() == 0) begin
            chk("unexpected_push", {bus.out_x, bus.out_y}, 32'hx);
          end else begin
            exp = sb_q.pop_front();
            chk("push_data", {bus.out_x, bus.out_y}, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic load(input logic [15:0] x, input logic [15:0] y, input bit expect_out);
    in_q.push_back({x, y});
    if (expect_out) sb_q.push_back({x + 16'd1, y + 16'd1});
  endtask

  task automatic start_batch(input logic [7:0] len);
    tick(); cfg_len = len; cfg_start = 1'b1;
    tick(); cfg_start = 1'b0;
  endtask

  task automatic clear_irq();
    tick(); irq_clear = 1'b1;
    tick(); irq_clear = 1'b0;
    @(negedge clk); chk("irq_cleared", irq, 1'b0);
  endtask

  task automatic wait_pushes(input int n);
    int seen = 0;
    int budget = 400;
    push_cyc.delete();
    while (seen < n && budget > 0) begin
      @(negedge clk); budget--;
      if (bus.out_push) begin seen++; push_cyc.push_back(cyc); end
    end
    chk("push_count", seen, n);
  endtask

  task automatic wait_idle();
    int budget = 400;
    while (busy && budget > 0) begin @(negedge clk); budget--; end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_for(input int which, input string name);
    int   budget = 200;
    logic hit = 1'b0;
    while (!hit && budget > 0) begin
      @(negedge clk); budget--;
      case (which)
        0:       hit = bus.core_start;
        1:       hit = bus.core_done;
        default: hit = bus.out_push;
      endcase
    end
    chk(name, hit, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_cnt"}, done_count, 8'd0);
    chk({tag, "_flags"}, {aborted, irq}, 2'b00);
    chk({tag, "_pulses"}, {bus.in_pop, bus.core_start, bus.out_push}, 3'b000);
    chk({tag, "_core_xy"}, {bus.core_x, bus.core_y}, 32'd0);
    chk({tag, "_out_xy"}, {bus.out_x, bus.out_y}, 32'd0);
  endtask

  initial begin : main
    int          p0, s0, q0, len;
    bit          bad;
    logic [15:0] x, y;
    logic [31:0] e;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_len = '0; cfg_abort = 1'b0; irq_clear = 1'b0;
    starve = 0; force_full = 0; rand_full = 0; rand_starve = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    tick(); rst_n = 1'b1;

    // Basic batch: three points, k=4, 7 cycles per point
    k_lat = 4;
    load(16'd1, 16'd2, 1); load(16'd3, 16'd4, 1); load(16'd5, 16'd6, 1);
    start_batch(8'd3);
    wait_pushes(3);
    chk("basic_irq_at_push", irq, 1'b0);
    if (push_cyc.size() == 3) begin
      chk("basic_period_1", 32'(push_cyc[1] - push_cyc[0]), 32'd7);
      chk("basic_period_2", 32'(push_cyc[2] - push_cyc[1]), 32'd7);
    end
    @(negedge clk);
    chk("basic_irq_after", irq, 1'b1);
    chk("basic_busy", busy, 1'b0);
    chk("basic_count", done_count, 8'd3);

    // Zero length batch
    clear_irq();
    p0 = n_pop; s0 = n_start;
    start_batch(8'd0);
    @(negedge clk);
    chk("zero_irq", irq, 1'b1);
    chk("zero_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("zero_no_pop_start", n_pop - p0 + n_start - s0, 0);

    // Input starvation
    starve = 1;
    load(16'h0010, 16'h0020, 1); load(16'h0030, 16'h0040, 1);
    p0 = n_pop;
    start_batch(8'd2);
    repeat (5) @(negedge clk);
    chk("starve_no_pop", n_pop - p0, 0);
    chk("starve_busy", busy, 1'b1);
    tick(); starve = 0;
    @(negedge clk); @(negedge clk);
    chk("starve_pop_on_fall", {bus.in_empty, bus.in_pop}, 2'b01);
    wait_pushes(2);
    wait_idle();
    chk("starve_count", done_count, 8'd2);

    // Backpressure on the output FIFO
    k_lat = 2; force_full = 1;
    x = 16'($urandom); y = 16'($urandom); e = {x + 16'd1, y + 16'd1};
    load(x, y, 1);
    s0 = n_start; q0 = n_push;
    start_batch(8'd1);
    wait_for(1, "bp_core_done");
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_push || {bus.out_x, bus.out_y} !== e) bad = 1;
    end
    chk("bp_held", bad, 1'b0);
    chk("bp_data", {bus.out_x, bus.out_y}, e);
    tick(); force_full = 0;
    wait_pushes(1);
    wait_idle();
    chk("bp_single_push", n_push - q0, 1);
    chk("bp_single_start", n_start - s0, 1);

    // Abort in WAIT_CORE with cfg_start during DRAIN
    clear_irq();
    k_lat = 4;
    load(16'h1111, 16'h2222, 0); load(16'h3333, 16'h4444, 0);
    p0 = n_pop; q0 = n_push;
    start_batch(8'd2);
    wait_for(0, "abw_core_start");
    tick(); cfg_abort = 1'b1;
    tick(); cfg_abort = 1'b0; cfg_len = 8'd5; cfg_start = 1'b1;
    tick(); cfg_start = 1'b0;
    @(negedge clk);
    chk("abw_drain_busy", busy, 1'b1);
    wait_idle();
    bad = 0;
    repeat (4) begin @(negedge clk); if (busy) bad = 1; end
    chk("abw_start_ignored", bad, 1'b0);
    chk("abw_flags", {aborted, irq}, 2'b10);
    chk("abw_count", done_count, 8'd0);
    chk("abw_no_push", n_push - q0, 0);
    chk("abw_one_pop", n_pop - p0, 1);
    in_q.delete();

    // Abort in FETCH takes priority over a ready pop
    load(16'h5555, 16'h6666, 0);
    p0 = n_pop;
    start_batch(8'd1);
    cfg_abort = 1'b1;
    tick(); cfg_abort = 1'b0;
    @(negedge clk);
    chk("abf_idle", busy, 1'b0);
    chk("abf_no_pop", n_pop - p0, 0);
    chk("abf_aborted", aborted, 1'b1);
    in_q.delete();

    // Reset while pushing
    k_lat = 3;
    for (int i = 0; i < 3; i++) load(16'($urandom), 16'($urandom), 1);
    start_batch(8'd3);
    wait_for(2, "rst_push_seen");
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    in_q.delete(); sb_q.delete();
    tick(); tick(); rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_after");
    load(16'($urandom), 16'($urandom), 1); load(16'($urandom), 16'($urandom), 1);
    start_batch(8'd2);
    wait_pushes(2);
    wait_idle();
    chk("rst_clean_count", done_count, 8'd2);
    chk("rst_clean_irq", irq, 1'b1);

    // irq_clear coincides with the final push
    clear_irq();
    k_lat = 2;
    load(16'h0abc, 16'h0def, 1);
    start_batch(8'd1);
    wait_for(2, "race_push_seen");
    #1 irq_clear = 1'b1;
    tick(); irq_clear = 1'b0;
    @(negedge clk);
    chk("race_irq_set_wins", irq, 1'b1);

    // Randomized batches with random latency, starvation and backpressure
    for (int b = 0; b < 8; b++) begin
      clear_irq();
      len = $urandom_range(1, 6);
      k_lat = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) load(16'($urandom), 16'($urandom), 1);
      rand_full = 1; rand_starve = 1;
      start_batch(8'(len));
      wait_pushes(len);
      wait_idle();
      rand_full = 0; rand_starve = 0;
      chk("rand_count", done_count, 32'(len));
      chk("rand_irq", irq, 1'b1);
      chk("rand_fifo_drained", in_q.size(), 0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
